// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: the ALU-stage bundle it consumes, the write-back bundle it
// produces, the stage FSM encoding and the word-address increment helper.
package mem_stage_pkg;

    // mem_word selects a 16-bit access; when clear the access is a single byte.
    typedef struct packed {
        logic [15:0] data_out;
        logic [1:0]  reg_write;
        logic [3:0]  reg_dest;
        logic        setPC;
        logic        mem_read;
        logic        mem_write;
        logic        mem_word;
        logic [23:0] mem_addr;
    } alu_signals;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  reg_write;
        logic [3:0]  reg_dest;
        logic        setPC;
    } wb_signals;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER1 = 2'd1,
        XFER2 = 2'd2,
        WB    = 2'd3
    } mem_state_e;

    // Word address of byte address a+1, wrapping 0xFFFFFF to 0x000000.
    function automatic logic [22:0] next_word_addr(input logic [23:0] a);
        return a[23:1] + {22'd0, a[0]};
    endfunction

endpackage

// File: rtl/mem_stage_lane_mux.sv
// Combinational lane steering: byte replication / word alignment on writes, lane extraction and
// zero-extension on reads. Honours MEM_STAGE_UNALIGNED_SPLIT_EN for odd word accesses.
module mem_lane_mux (
    input  logic        word,
    input  logic        odd,
    input  logic        wr_second,
    input  logic [15:0] data,
    input  logic [15:0] rdata,
    input  logic [7:0]  first_byte,
    output logic [1:0]  be,
    output logic [15:0] wdata,
    output logic [15:0] rresult
);

    logic split_s;

`ifdef MEM_STAGE_UNALIGNED_SPLIT_EN
    assign split_s = word & odd;
`else
    assign split_s = 1'b0;
`endif

    // Lane enables, write data and read result for the current access phase
    always_comb begin
        be      = 2'b11;
        wdata   = data;
        rresult = rdata;
        if (!word) begin
            be      = odd ? 2'b10 : 2'b01;
            wdata   = {data[7:0], data[7:0]};
            rresult = {8'h00, (odd ? rdata[15:8] : rdata[7:0])};
        end else if (split_s) begin
            be      = wr_second ? 2'b01 : 2'b10;
            wdata   = wr_second ? {data[15:8], data[15:8]} : {data[7:0], data[7:0]};
            rresult = {rdata[7:0], first_byte};
        end else begin
            be      = 2'b11;
            wdata   = data;
            rresult = rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: req/ack bus transfer for byte/word loads and stores, then write-back.
// Optional odd-address word splitting is enabled by defining MEM_STAGE_UNALIGNED_SPLIT_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  alu_signals  control_signals_in,
    output logic        busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [22:0] bus_addr,
    output logic [1:0]  bus_be,
    output logic [15:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [1:0]  wb_reg_write,
    output logic [3:0]  wb_reg_dest,
    output logic        wb_setPC,
    output logic        err
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    mem_state_e  state_r;
    alu_signals  op_r;
    wb_signals   wb_r;
    logic [7:0]  first_byte_r;
    logic [CW-1:0] wait_cnt_r;
    logic        busy_r;
    logic        bus_req_r;
    logic        bus_we_r;
    logic [22:0] bus_addr_r;
    logic [1:0]  bus_be_r;
    logic [15:0] bus_wdata_r;
    logic        wb_valid_r;
    logic        err_r;

    alu_signals  src_s;
    logic        split_s;
    logic        timeout_s;
    logic [1:0]  be_s;
    logic [15:0] wdata_s;
    logic [15:0] rresult_s;

    // While idle the lane mux looks at the incoming bundle so the first transfer can launch at once
    assign src_s = (state_r == IDLE) ? control_signals_in : op_r;

`ifdef MEM_STAGE_UNALIGNED_SPLIT_EN
    assign split_s = op_r.mem_word & op_r.mem_addr[0];
`else
    assign split_s = 1'b0;
`endif

    mem_lane_mux u_lane_mux (
        .word       (src_s.mem_word),
        .odd        (src_s.mem_addr[0]),
        .wr_second  (state_r == XFER1),
        .data       (src_s.data_out),
        .rdata      (bus_rdata),
        .first_byte (first_byte_r),
        .be         (be_s),
        .wdata      (wdata_s),
        .rresult    (rresult_s)
    );

    // Wait-limit detection on the cycle that would be the WAIT_LIMIT-th unacknowledged one
    always_comb begin
        timeout_s = 1'b0;
        if (WAIT_LIMIT != 0 && bus_req_r && !bus_ack) begin
            timeout_s = (wait_cnt_r == CW'(WAIT_LIMIT - 1));
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Stage FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            op_r         <= '0;
            wb_r         <= '0;
            first_byte_r <= 8'h00;
            wait_cnt_r   <= CW'(0);
            busy_r       <= 1'b0;
            bus_req_r    <= 1'b0;
            bus_we_r     <= 1'b0;
            bus_addr_r   <= 23'd0;
            bus_be_r     <= 2'b00;
            bus_wdata_r  <= 16'h0000;
            wb_valid_r   <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            wb_valid_r <= 1'b0;
            err_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (en) begin
                        op_r       <= control_signals_in;
                        busy_r     <= 1'b1;
                        wait_cnt_r <= CW'(0);
                        if (control_signals_in.mem_read || control_signals_in.mem_write) begin
                            state_r     <= XFER1;
                            bus_req_r   <= 1'b1;
                            bus_we_r    <= control_signals_in.mem_write;
                            bus_addr_r  <= control_signals_in.mem_addr[23:1];
                            bus_be_r    <= be_s;
                            bus_wdata_r <= wdata_s;
                        end else begin
                            state_r <= WB;
                        end
                    end
                end
                XFER1, XFER2: begin
                    if (bus_ack) begin
                        if (state_r == XFER1 && split_s) begin
                            state_r      <= XFER2;
                            first_byte_r <= bus_rdata[15:8];
                            bus_addr_r   <= next_word_addr(op_r.mem_addr);
                            bus_be_r     <= be_s;
                            bus_wdata_r  <= wdata_s;
                            wait_cnt_r   <= CW'(0);
                        end else begin
                            state_r    <= WB;
                            bus_req_r  <= 1'b0;
                            busy_r     <= 1'b0;
                            wb_valid_r <= 1'b1;
                            wb_r       <= '{data:      (op_r.mem_write ? op_r.data_out : rresult_s),
                                            reg_write: op_r.reg_write,
                                            reg_dest:  op_r.reg_dest,
                                            setPC:     op_r.setPC};
                        end
                    end else if (timeout_s) begin
                        state_r   <= IDLE;
                        bus_req_r <= 1'b0;
                        busy_r    <= 1'b0;
                        err_r     <= 1'b1;
                    end else if (WAIT_LIMIT != 0) begin
                        wait_cnt_r <= wait_cnt_r + CW'(1);
                    end
                end
                WB: begin
                    state_r <= IDLE;
                    // Memory ops already pulsed on the ack edge; only register-only ops pulse here
                    if (!(op_r.mem_read || op_r.mem_write)) begin
                        busy_r     <= 1'b0;
                        wb_valid_r <= 1'b1;
                        wb_r       <= '{data:      op_r.data_out,
                                        reg_write: op_r.reg_write,
                                        reg_dest:  op_r.reg_dest,
                                        setPC:     op_r.setPC};
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign bus_req      = bus_req_r;
    assign bus_we       = bus_we_r;
    assign bus_addr     = bus_addr_r;
    assign bus_be       = bus_be_r;
    assign bus_wdata    = bus_wdata_r;
    assign wb_valid     = wb_valid_r;
    assign wb_data      = wb_r.data;
    assign wb_reg_write = wb_r.reg_write;
    assign wb_reg_dest  = wb_r.reg_dest;
    assign wb_setPC     = wb_r.setPC;
    assign err          = err_r;

endmodule
